bcd_operand_ctrl: RTL and testbench
===================================

BCD_OPERAND_CTRL -- requirements
Module: bcd_operand_ctrl

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, meaning number of BCD digits per operand.
REQ-002 The block SHALL have parameter BIN_W, default 14, meaning binary result width (holds 9999).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 key_valid  input  1  a digit key is present this cycle.
REQ-007 key_digit  input  4  BCD digit value.
REQ-008 key_clr  input  1  clear the operand.
REQ-009 key_enter  input  1  start the conversion.
REQ-010 out_ready  input  1  the consumer accepts the result.
REQ-011 out_valid  output  1  the result is valid.
REQ-012 out_bin  output  BIN_W  binary value of the operand.
REQ-013 out_bcd  output  4*NDIG  current BCD operand, for display.
REQ-014 busy  output  1  high in CONV.
REQ-015 err  output  1  one-cycle pulse on a rejected digit (macro only; tied 0 otherwise).

Function
REQ-016 The FSM SHALL have states IDLE (collect), CONV (convert), HOLD (present result).
REQ-017 Input priority SHALL be key_clr > key_enter > key_valid; lower-priority inputs in the same cycle are dropped.
REQ-018 In IDLE, an accepted digit SHALL shift in from the LSD: bcd <= {bcd[4*NDIG-5:0], key_digit}, and the digit count SHALL increment.
REQ-019 When count==NDIG, further digits SHALL be ignored: no shift, count saturates.
REQ-020 key_clr in IDLE or HOLD SHALL zero bcd, count, acc and out_valid, and go to IDLE.
REQ-021 key_enter in IDLE SHALL go to CONV, with acc=0 and idx=NDIG-1.
REQ-022 Each CONV cycle SHALL compute acc <= acc*10 + bcd[4*idx +: 4], then decrement idx.
REQ-023 CONV SHALL last exactly NDIG cycles, leaving after the idx==0 update.
REQ-024 If key_enter is sampled on edge E, out_valid SHALL be high after edge E+NDIG.
REQ-025 Arithmetic SHALL be truncated modulo 2^BIN_W.
REQ-026 key_* inputs (including key_clr) SHALL be ignored in CONV.
REQ-027 In HOLD, out_valid=1 and out_bin=acc SHALL remain stable until out_ready.
REQ-028 out_valid&&out_ready SHALL clear bcd and count and return to IDLE on that edge.
REQ-029 out_valid SHALL NOT depend combinationally on out_ready.
REQ-030 key_enter with count==0 SHALL convert to out_bin=0.

Reset
REQ-031 On rst, the block SHALL go to IDLE and zero bcd, count, idx and acc.
REQ-032 On rst, out_valid, busy and err SHALL be 0.
REQ-033 rst mid-CONV or mid-HOLD SHALL abort with no out_valid pulse.

Configuration
REQ-034 With BCD_DIGIT_CHECK_EN defined, a key_digit >9 SHALL be rejected (no shift, no count change) and err SHALL pulse for 1 cycle.
REQ-035 Without BCD_DIGIT_CHECK_EN, digits >9 SHALL be accepted raw, converted per REQ-022/REQ-025, and err SHALL be tied 0.

Structure
REQ-036 Package bcd_calc_pkg SHALL hold the state enum, NDIG/BIN_W defaults and the BCD digit type.
REQ-037 The combinational acc*10+digit step SHALL be sub-module bcd_mac10, which is reusable by the calculator datapath.

Verification
REQ-038 Keys 1,2,3,4 then enter -> busy for 4 cycles; out_valid after edge E+4; out_bin=1234; out_bcd=16'h1234.
REQ-039 Keys 9,9,9,9,5 -> fifth digit ignored; out_bcd=16'h9999; enter -> out_bin=9999.
REQ-040 Hold out_ready=0 for 10 cycles after a result -> out_valid and out_bin stable; out_ready=1 -> IDLE next edge, out_bcd=0.
REQ-041 key_valid, key_enter and key_clr together in IDLE -> cleared, no CONV; rst in 2nd CONV cycle -> IDLE, out_valid never 1.
REQ-042 key_digit=4'hC: with macro -> err pulse, bcd unchanged; without macro -> digits C,0,0,0 give out_bin=12000.
REQ-043 Enter with no digits -> out_bin=0; key_clr in HOLD -> out_valid drops next edge.

Source files
------------

// File: rtl/bcd_calc_pkg.sv
// ---------------------------------------------------------------------------
// bcd_calc_pkg
//   Shared types and defaults for the BCD calculator blocks.
//   - NDIG_DEF / BIN_W_DEF : default operand digit count / binary result width
//   - ctrl_state_t         : operand controller FSM states
//   - bcd_digit_t          : one packed BCD digit
// ---------------------------------------------------------------------------
package bcd_calc_pkg;

    localparam int NDIG_DEF  = 4;
    localparam int BIN_W_DEF = 14;   // 9999 fits in 14 bits

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // collecting digits
        ST_CONV = 2'd1,   // BCD -> binary, one digit per cycle
        ST_HOLD = 2'd2    // presenting result until accepted
    } ctrl_state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage : bcd_calc_pkg

// File: rtl/bcd_operand_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_operand_ctrl_if
//   Keypad/result bundle for bcd_operand_ctrl.
//   master : keypad + result consumer side (drives key_*, out_ready)
//   slave  : operand controller side (drives out_*, busy, err)
// ---------------------------------------------------------------------------
interface bcd_operand_ctrl_if
    import bcd_calc_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int BIN_W = BIN_W_DEF
);
    logic               key_valid;
    bcd_digit_t         key_digit;
    logic               key_clr;
    logic               key_enter;
    logic               out_ready;
    logic               out_valid;
    logic [BIN_W-1:0]   out_bin;
    logic [4*NDIG-1:0]  out_bcd;
    logic               busy;
    logic               err;

    modport master (
        output key_valid, key_digit, key_clr, key_enter, out_ready,
        input  out_valid, out_bin, out_bcd, busy, err
    );

    modport slave (
        input  key_valid, key_digit, key_clr, key_enter, out_ready,
        output out_valid, out_bin, out_bcd, busy, err
    );

endinterface : bcd_operand_ctrl_if

// File: rtl/bcd_mac10.sv
// ---------------------------------------------------------------------------
// bcd_mac10
//   Combinational decimal accumulate step: res = acc*10 + digit, truncated
//   to BIN_W bits. Shared with the calculator datapath.
//   acc   : running binary value
//   digit : next BCD digit (raw 4 bits, values >9 are not filtered here)
//   res   : updated value, modulo 2^BIN_W
// ---------------------------------------------------------------------------
module bcd_mac10
    import bcd_calc_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic [BIN_W-1:0] acc,
    input  bcd_digit_t       digit,
    output logic [BIN_W-1:0] res
);

    // Everything evaluates at BIN_W, so the wrap is implicit.
    assign res = acc * BIN_W'(10) + BIN_W'(digit);

endmodule : bcd_mac10

// File: rtl/bcd_operand_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_operand_ctrl
//   Collects up to NDIG BCD digits from a keypad, converts the operand to
//   binary over NDIG cycles (MSD first), and presents the result with a
//   valid/ready handshake.
//
//   clk, rst : clock, synchronous active-high reset
//   bus      : bcd_operand_ctrl_if.slave
//              key_valid/key_digit/key_clr/key_enter in (clr > enter > digit)
//              out_ready in; out_valid/out_bin/out_bcd/busy/err out
//
//   Optional: define BCD_DIGIT_CHECK_EN to reject digits >9 with a one-cycle
//   err pulse; otherwise raw digits are accepted and err is tied low.
// ---------------------------------------------------------------------------
module bcd_operand_ctrl
    import bcd_calc_pkg::*;
#(
    parameter int NDIG  = NDIG_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    bcd_operand_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(NDIG + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    ctrl_state_t        state_q, state_d;
    logic [4*NDIG-1:0]  bcd_q,   bcd_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [BIN_W-1:0]   acc_q,   acc_d;

    bcd_digit_t         cur_digit;
    logic [BIN_W-1:0]   mac_res;
    logic [4*NDIG+3:0]  shifted;
    logic               digit_ok;

    // Digit under conversion, MSD first.
    assign cur_digit = bcd_q[4*idx_q +: 4];
    // New digit enters at the LSD; the old MSD falls off the top.
    assign shifted   = {bcd_q, bus.key_digit};

    bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
        .acc   (acc_q),
        .digit (cur_digit),
        .res   (mac_res)
    );

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;
    assign digit_ok = (bus.key_digit <= 4'd9);
    assign bus.err  = err_q;
`else
    assign digit_ok = 1'b1;
    assign bus.err  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.key_clr) begin
                    bcd_d = '0;
                    cnt_d = '0;
                    acc_d = '0;
                end else if (bus.key_enter) begin
                    state_d = ST_CONV;
                    acc_d   = '0;
                    idx_d   = IDX_W'(NDIG - 1);
                end else if (bus.key_valid) begin
                    if (!digit_ok) begin
`ifdef BCD_DIGIT_CHECK_EN
                        err_d = 1'b1;
`endif
                    end else if (cnt_q != CNT_W'(NDIG)) begin
                        // Full operand: extra digits are silently dropped.
                        bcd_d = shifted[4*NDIG-1:0];
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CONV: begin
                // Keys (including clear) are ignored while converting.
                acc_d = mac_res;
                if (idx_q == '0) state_d = ST_HOLD;
                else             idx_d   = idx_q - IDX_W'(1);
            end
            ST_HOLD: begin
                if (bus.key_clr) begin
                    state_d = ST_IDLE;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (bus.out_ready) begin
                    // Result consumed; acc keeps its value but is no longer shown valid.
                    state_d = ST_IDLE;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // All outputs are pure state decodes: no path from out_ready.
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q == ST_CONV);
    assign bus.out_bin   = acc_q;
    assign bus.out_bcd   = bcd_q;

endmodule : bcd_operand_ctrl

// File: tb/tb_bcd_operand_ctrl.sv
module tb_bcd_operand_ctrl;
    import bcd_calc_pkg::*;

    localparam int NDIG  = 4;
    localparam int BIN_W = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bcd_operand_ctrl_if #(.NDIG(NDIG), .BIN_W(BIN_W)) bus ();

    bcd_operand_ctrl #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs set before the call are sampled on it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        step();
        bus.key_enter = 1'b0;
    endtask

    // Bounded wait for a result, then check it.
    task automatic wait_result(input string tag, input logic [31:0] exp);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
        chk(tag, 32'(bus.out_bin), exp);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
        bus.key_clr   = 1'b0;
        bus.key_enter = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_bcd",   32'(bus.out_bcd),   32'd0);
        chk("rst_err",   32'(bus.err),       32'd0);

        // 1,2,3,4 + enter: exact NDIG-cycle latency.
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        chk("bcd_1234", 32'(bus.out_bcd), 32'h1234);
        enter();
        for (int i = 0; i < NDIG; i++) begin
            chk($sformatf("busy_c%0d", i),  32'(bus.busy),      32'd1);
            chk($sformatf("nvld_c%0d", i),  32'(bus.out_valid), 32'd0);
            step();
        end
        chk("vld_e4",   32'(bus.out_valid), 32'd1);
        chk("busy_e4",  32'(bus.busy),      32'd0);
        chk("bin_1234", 32'(bus.out_bin),   32'd1234);

        // Hold stability without ready, then accept.
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_vld", 32'(bus.out_valid), 32'd1);
            chk("hold_bin", 32'(bus.out_bin),   32'd1234);
        end
        accept();
        chk("acc_vld", 32'(bus.out_valid), 32'd0);
        chk("acc_bcd", 32'(bus.out_bcd),   32'd0);

        // Saturation: fifth digit ignored.
        key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'd5);
        chk("bcd_9999", 32'(bus.out_bcd), 32'h9999);
        enter();
        wait_result("bin_9999", 32'd9999);
        accept();

        // Clear + enter + digit together: clear wins, no conversion.
        key(4'd5); key(4'd6);
        bus.key_clr = 1'b1; bus.key_enter = 1'b1; bus.key_valid = 1'b1; bus.key_digit = 4'd7;
        step();
        bus.key_clr = 1'b0; bus.key_enter = 1'b0; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
        chk("prio_bcd",  32'(bus.out_bcd), 32'd0);
        chk("prio_busy", 32'(bus.busy),    32'd0);
        step();
        chk("prio_busy2", 32'(bus.busy),   32'd0);

        // Reset sampled in the second CONV cycle aborts.
        key(4'd7);
        enter();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy),    32'd0);
        chk("abort_bcd",  32'(bus.out_bcd), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_nvld", 32'(bus.out_valid), 32'd0);
            step();
        end

        // Clear ignored during CONV.
        key(4'd2); key(4'd1);
        enter();
        bus.key_clr = 1'b1;
        step();
        bus.key_clr = 1'b0;
        wait_result("bin_21", 32'd21);
        accept();

        // Empty enter converts to 0; clear in HOLD drops valid next edge.
        enter();
        wait_result("bin_empty", 32'd0);
        bus.key_clr = 1'b1;
        step();
        bus.key_clr = 1'b0;
        chk("clr_hold_vld", 32'(bus.out_valid), 32'd0);

`ifdef BCD_DIGIT_CHECK_EN
        key(4'd3);
        key(4'hC);
        chk("err_pulse", 32'(bus.err),     32'd1);
        chk("err_bcd",   32'(bus.out_bcd), 32'h0003);
        step();
        chk("err_end",   32'(bus.err),     32'd0);
        bus.key_clr = 1'b1; step(); bus.key_clr = 1'b0;
`else
        key(4'hC);
        chk("raw_err", 32'(bus.err), 32'd0);
        key(4'd0); key(4'd0); key(4'd0);
        chk("raw_bcd", 32'(bus.out_bcd), 32'hC000);
        enter();
        wait_result("bin_c000", 32'd12000);
        accept();
        // 15*1111 = 16665 wraps mod 16384 to 281.
        key(4'hF); key(4'hF); key(4'hF); key(4'hF);
        enter();
        wait_result("bin_wrap", 32'd281);
        accept();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_bcd_operand_ctrl
